// File: rtl/ts_frame_aligner_if.sv
// Link-side word stream and frame-recovery outputs of one trigger-scintillator link.
// master: receiver/monitor side (drives rx_*), slave: the frame aligner.
interface ts_frame_aligner_if;
    logic [15:0] rx_d;
    logic [1:0]  rx_k;
    logic        rx_err;
    logic [15:0] out_d;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic [7:0]  out_bx;
    logic        frame_good;
    logic        frame_bad;
    logic        aligned;
    logic [31:0] good_count;
    logic [31:0] bad_count;

    modport master (
        output rx_d, rx_k, rx_err,
        input  out_d, out_valid, out_sof, out_eof, out_bx,
        input  frame_good, frame_bad, aligned, good_count, bad_count
    );

    modport slave (
        input  rx_d, rx_k, rx_err,
        output out_d, out_valid, out_sof, out_eof, out_bx,
        output frame_good, frame_bad, aligned, good_count, bad_count
    );
endinterface

// File: rtl/ts_frame_aligner.sv
// Frame recovery for one trigger-scintillator link: comma hunt, data forwarding, frame verdict,
// lock flag and saturating frame counters. Define TS_FRAME_CSUM_EN to enforce the frame checksum.
module ts_frame_aligner #(
    parameter int NDATA     = 6,
    parameter int LOCK_GOOD = 4
) (
    input  logic                 rx_clk,
    input  logic                 reset,
    ts_frame_aligner_if.slave    link
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_CSUM = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  bx_q, bx_d;
    logic [15:0] od_q, od_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        good_q, good_d;
    logic        bad_q, bad_d;
    logic [3:0]  cons_q, cons_d;
    logic        al_q, al_d;
    logic [31:0] gc_q, gc_d;
    logic [31:0] bc_q, bc_d;
`ifdef TS_FRAME_CSUM_EN
    logic [15:0] sum_q, sum_d;
`endif

    logic is_hdr_s;
    logic data_ok_s;
    logic csum_ok_s;
    logic start_s;
    logic good_s;
    logic bad_s;
    logic [3:0] cons_inc_s;

    assign is_hdr_s  = (link.rx_k == 2'b01) && (link.rx_d[7:0] == 8'hBC) && !link.rx_err;
    assign data_ok_s = (link.rx_k == 2'b00) && !link.rx_err;
`ifdef TS_FRAME_CSUM_EN
    assign csum_ok_s = (link.rx_d == sum_q);
`else
    assign csum_ok_s = 1'b1;
`endif

    // Next-state: framing FSM, data path and verdict, then lock/counter update from the verdict.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bx_d       = bx_q;
        od_d       = od_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        start_s    = 1'b0;
        good_s     = 1'b0;
        bad_s      = 1'b0;
`ifdef TS_FRAME_CSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            ST_HUNT: begin
                if (is_hdr_s) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (is_hdr_s) begin
                    bad_s   = 1'b1;
                    start_s = 1'b1;
                end else if (data_ok_s) begin
                    od_d    = link.rx_d;
                    valid_d = 1'b1;
                    sof_d   = (cnt_q == 8'd0);
                    eof_d   = (cnt_q == 8'(NDATA - 1));
                    cnt_d   = cnt_q + 8'd1;
`ifdef TS_FRAME_CSUM_EN
                    sum_d   = sum_q + link.rx_d;
`endif
                    if (cnt_q == 8'(NDATA - 1)) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    bad_s   = 1'b1;
                    state_d = ST_HUNT;
                end
            end
            ST_CSUM: begin
                if (is_hdr_s) begin
                    bad_s   = 1'b1;
                    start_s = 1'b1;
                end else if (data_ok_s) begin
                    good_s  = csum_ok_s;
                    bad_s   = !csum_ok_s;
                    state_d = ST_HUNT;
                end else begin
                    bad_s   = 1'b1;
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // A header always opens a fresh frame, even when it also closes a broken one.
        if (start_s) begin
            bx_d    = link.rx_d[15:8];
            cnt_d   = 8'd0;
            state_d = ST_DATA;
`ifdef TS_FRAME_CSUM_EN
            sum_d   = link.rx_d;
`endif
        end else begin
            bx_d = bx_d;
        end

        good_d     = good_s;
        bad_d      = bad_s;
        cons_inc_s = (cons_q >= 4'(LOCK_GOOD)) ? 4'(LOCK_GOOD) : (cons_q + 4'd1);
        if (good_s) begin
            cons_d = cons_inc_s;
            al_d   = al_q | (cons_inc_s == 4'(LOCK_GOOD));
            gc_d   = (gc_q == 32'hFFFF_FFFF) ? gc_q : (gc_q + 32'd1);
            bc_d   = bc_q;
        end else if (bad_s) begin
            cons_d = 4'd0;
            al_d   = 1'b0;
            gc_d   = gc_q;
            bc_d   = (bc_q == 32'hFFFF_FFFF) ? bc_q : (bc_q + 32'd1);
        end else begin
            cons_d = cons_q;
            al_d   = al_q;
            gc_d   = gc_q;
            bc_d   = bc_q;
        end
    end

    // State and output registers; reset clears everything immediately, mid-frame included.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HUNT;
            cnt_q   <= 8'd0;
            bx_q    <= 8'd0;
            od_q    <= 16'd0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            cons_q  <= 4'd0;
            al_q    <= 1'b0;
            gc_q    <= 32'd0;
            bc_q    <= 32'd0;
`ifdef TS_FRAME_CSUM_EN
            sum_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bx_q    <= bx_d;
            od_q    <= od_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            cons_q  <= cons_d;
            al_q    <= al_d;
            gc_q    <= gc_d;
            bc_q    <= bc_d;
`ifdef TS_FRAME_CSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign link.out_d      = od_q;
    assign link.out_valid  = valid_q;
    assign link.out_sof    = sof_q;
    assign link.out_eof    = eof_q;
    assign link.out_bx     = bx_q;
    assign link.frame_good = good_q;
    assign link.frame_bad  = bad_q;
    assign link.aligned    = al_q;
    assign link.good_count = gc_q;
    assign link.bad_count  = bc_q;

endmodule

// File: tb/tb_ts_frame_aligner.sv
// Directed bench for ts_frame_aligner: vector table plus hand-written reset, NDATA=1 and saturation sequences.
module tb_ts_frame_aligner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ts_frame_aligner_if lk ();
    ts_frame_aligner_if lk1 ();

    assign lk1.rx_d   = lk.rx_d;
    assign lk1.rx_k   = lk.rx_k;
    assign lk1.rx_err = lk.rx_err;

    ts_frame_aligner #(.NDATA(6), .LOCK_GOOD(4)) dut  (.rx_clk(clk), .reset(rst), .link(lk));
    ts_frame_aligner #(.NDATA(1), .LOCK_GOOD(4)) dut1 (.rx_clk(clk), .reset(rst), .link(lk1));

    typedef struct {
        logic [1:0]  k;
        logic        e;
        logic [15:0] d;
        logic        v, sof, eof, g, b, al;
        logic [15:0] od;
        logic [7:0]  bx;
        logic [31:0] gc, bc;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_od = 16'h0000;
    logic [7:0]  m_bx = 8'h00;
    logic        m_al = 1'b0;
    logic [31:0] m_gc = 32'd0;
    logic [31:0] m_bc = 32'd0;

    task automatic push(input logic [1:0] k, input logic e, input logic [15:0] d,
                        input logic v, input logic sof, input logic eof, input logic g, input logic b);
        vec_t x;
        x.k = k; x.e = e; x.d = d; x.v = v; x.sof = sof; x.eof = eof; x.g = g; x.b = b;
        x.al = m_al; x.od = m_od; x.bx = m_bx; x.gc = m_gc; x.bc = m_bc;
        vecs.push_back(x);
    endtask

    task automatic ign(input logic [1:0] k, input logic e, input logic [15:0] d);
        push(k, e, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hdr(input logic [7:0] bx);
        m_bx = bx;
        push(2'b01, 1'b0, {bx, 8'hBC}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hdr_bad(input logic [7:0] bx);
        m_bx = bx; m_bc = m_bc + 32'd1; m_al = 1'b0;
        push(2'b01, 1'b0, {bx, 8'hBC}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic data_w(input logic [15:0] w, input logic sof, input logic eof);
        m_od = w;
        push(2'b00, 1'b0, w, 1'b1, sof, eof, 1'b0, 1'b0);
    endtask

    task automatic data_run(input int n);
        for (int i = 1; i <= n; i++) data_w(16'(i), i == 1, i == 6);
    endtask

    task automatic csum_good(input logic [15:0] c, input logic al);
        m_gc = m_gc + 32'd1; m_al = al;
        push(2'b00, 1'b0, c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic verdict_bad(input logic [1:0] k, input logic e, input logic [15:0] d);
        m_bc = m_bc + 32'd1; m_al = 1'b0;
        push(k, e, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [95:0] dut_vec();
        return {2'b00, lk.out_valid, lk.out_sof, lk.out_eof, lk.frame_good, lk.frame_bad, lk.aligned,
                lk.out_d, lk.out_bx, lk.good_count, lk.bad_count};
    endfunction

    function automatic logic [95:0] exp_vec(input vec_t x);
        return {2'b00, x.v, x.sof, x.eof, x.g, x.b, x.al, x.od, x.bx, x.gc, x.bc};
    endfunction

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] k, input logic e, input logic [15:0] d);
        lk.rx_k = k; lk.rx_err = e; lk.rx_d = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        lk.rx_k = 2'b11; lk.rx_err = 1'b0; lk.rx_d = 16'h0000;

        // Vector table: expected outputs are those seen one cycle after each input word.
        ign(2'b11, 1'b0, 16'h0000);
        ign(2'b01, 1'b1, 16'h12BC);
        ign(2'b00, 1'b0, 16'h1234);
        for (int f = 0; f < 5; f++) begin
            hdr(8'h12); data_run(6); csum_good(16'h12D1, f >= 3);
        end
        ign(2'b11, 1'b0, 16'h0000);
        hdr(8'h12); data_w(16'h0001, 1'b1, 1'b0); data_w(16'h0002, 1'b0, 1'b0);
        verdict_bad(2'b00, 1'b1, 16'h0003);
        ign(2'b00, 1'b0, 16'h0004);
        for (int f = 0; f < 4; f++) begin
            hdr(8'h12); data_run(6); csum_good(16'h12D1, f == 3);
        end
        hdr(8'h12); data_run(6);
`ifdef TS_FRAME_CSUM_EN
        verdict_bad(2'b00, 1'b0, 16'h12D0);
`else
        csum_good(16'h12D0, 1'b1);
`endif
        hdr(8'h12); data_run(4); hdr_bad(8'h34); data_run(6); csum_good(16'h34D1, 1'b0);
        hdr(8'h56); data_run(6); hdr_bad(8'h12); data_run(6); csum_good(16'h12D1, 1'b0);
        hdr(8'h12); data_w(16'h0001, 1'b1, 1'b0); verdict_bad(2'b10, 1'b0, 16'h0002);
        hdr(8'h12); data_w(16'h0001, 1'b1, 1'b0); verdict_bad(2'b01, 1'b0, 16'h0055);
        hdr(8'h12); data_run(6); verdict_bad(2'b11, 1'b0, 16'h12D1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_vec(), 96'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].k, vecs[i].e, vecs[i].d);
            chk($sformatf("vec%0d", i), dut_vec(), exp_vec(vecs[i]));
        end

        // Reset asserted mid-frame clears outputs at once and leaves no verdict behind.
        step(2'b01, 1'b0, 16'h77BC);
        step(2'b00, 1'b0, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        chk("reset_midframe", dut_vec(), 96'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b0, 16'h0002);
            chk($sformatf("post_reset%0d", i), {94'd0, lk.frame_bad, lk.out_valid}, 96'd0);
        end

        // NDATA=1 instance: single data word carries both sof and eof.
        step(2'b01, 1'b0, 16'h12BC);
        step(2'b00, 1'b0, 16'h0001);
        chk("nd1_word", {76'd0, lk1.out_valid, lk1.out_sof, lk1.out_eof, lk1.out_d, lk1.out_bx},
            {76'd0, 1'b1, 1'b1, 1'b1, 16'h0001, 8'h12});
        step(2'b00, 1'b0, 16'h12BD);
        chk("nd1_verdict", {94'd0, lk1.frame_good, lk1.frame_bad}, {94'd0, 1'b1, 1'b0});
        step(2'b11, 1'b0, 16'h0000);

        // Saturation: preload counters near the limit, then keep counting frames.
        force dut.gc_q = 32'hFFFF_FFFE;
        force dut.bc_q = 32'hFFFF_FFFF;
        #1;
        release dut.gc_q;
        release dut.bc_q;
        for (int f = 0; f < 2; f++) begin
            step(2'b01, 1'b0, 16'h12BC);
            for (int i = 1; i <= 6; i++) step(2'b00, 1'b0, 16'(i));
            step(2'b00, 1'b0, 16'h12D1);
            chk($sformatf("sat_good%0d", f), {63'd0, lk.frame_good, lk.good_count},
                {63'd0, 1'b1, 32'hFFFF_FFFF});
        end
        step(2'b01, 1'b0, 16'h12BC);
        step(2'b11, 1'b0, 16'h0000);
        chk("sat_bad", {63'd0, lk.frame_bad, lk.bad_count}, {63'd0, 1'b1, 32'hFFFF_FFFF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ts_frame_aligner.md
# ts_frame_aligner

Frame recovery stage for one trigger-scintillator link, directly downstream of the link receiver's 16-bit decoded word stream (`rx_d` / `rx_k` / `rx_err`). It:

- finds the header comma and counts out the fixed-length frame;
- forwards the frame's data words with start/end markers;
- validates each frame and reports a per-frame good/bad pulse;
- maintains a lock flag and 32-bit saturating good/bad frame counters for the status register bank.

One instance per link, clocked by that link's recovered clock.

## Interface

Parameters:
- `NDATA`, 6: data words per frame. Total frame is `NDATA`+2 words (header, data, checksum). Legal range 1–255.
- `LOCK_GOOD`, 4: consecutive good frames required to assert `aligned`. Legal range 1–15.

Ports (name, direction, width, meaning):
- `rx_clk` input 1: recovered link clock; the only clock.
- `reset` input 1: asynchronous, active-high reset.
- `rx_d` input 16: decoded word; byte 0 is `[7:0]`.
- `rx_k` input 2: K-flags; bit 0 applies to `[7:0]`.
- `rx_err` input 1: decode/disparity error for this word.
- `out_d` output 16: forwarded data word.
- `out_valid` output 1: `out_d` is a data word.
- `out_sof` output 1: first data word of a frame.
- `out_eof` output 1: last data word of a frame.
- `out_bx` output 8: header byte `[15:8]` of the current frame; held until the next header.
- `frame_good` output 1: one-cycle pulse, frame passed all checks.
- `frame_bad` output 1: one-cycle pulse, frame failed or was aborted.
- `aligned` output 1: link lock flag.
- `good_count` output 32: saturating count of good frames.
- `bad_count` output 32: saturating count of bad frames.

## Operation

Word classes:
- **Header:** `rx_k`=2'b01, `rx_d[7:0]`=8'hBC, `rx_err`=0.
- **Idle:** `rx_k`=2'b11, any data.
- **Data/checksum:** `rx_k`=2'b00.
- Any other `rx_k` pattern is illegal.

State machine: HUNT, DATA, CSUM.
- **HUNT:**
  - A header loads `out_bx`, sets `sum`=`rx_d`, clears the word counter and moves to DATA.
  - All other words are ignored, including `rx_err`; nothing is counted.
- **DATA:**
  - A legal word with `rx_err`=0 is forwarded and added to `sum` (16-bit modular add, carry discarded).
  - After `NDATA` such words, move to CSUM.
- **CSUM:**
  - A word with `rx_k`=00 and `rx_err`=0 completes the frame. Compare it with `sum` (see Configuration): match gives good, mismatch gives bad.
  - Return to HUNT.
- **Abort (DATA or CSUM only):**
  - Trigger: `rx_err`=1, idle, or illegal `rx_k`.
  - Result: the frame is bad; go to HUNT; `out_eof` is never issued for it.
- **Header seen in DATA or CSUM:**
  - The current frame is bad.
  - The new header is accepted in the same cycle as a fresh frame start (DATA).

Lock and counters:
- Good frame: increment the consecutive-good counter, saturating at `LOCK_GOOD`. `aligned` sets when the counter reaches `LOCK_GOOD`.
- Bad frame: clear the consecutive-good counter and `aligned`.
- `good_count` / `bad_count` increment per frame and stick at 32'hFFFFFFFF.

## Timing

- **Reset:** every output, the counters and `sum` go to 0; state goes to HUNT. The reset takes effect immediately and mid-frame; no pulse is generated for the interrupted frame.
- **Data path:** a data word input at cycle n appears on `out_d`/`out_valid` at n+1.
  - `out_sof` accompanies data word 1; `out_eof` accompanies data word `NDATA`.
  - With `NDATA`=1, `out_sof` and `out_eof` are asserted together.
- **Verdict:**
  - Good or bad frame decided on the checksum word: `frame_good` or `frame_bad` at n+1. `aligned` and the counters update in the same cycle as the pulse.
  - Aborting word at n: `frame_bad` at n+1.
  - `frame_good` and `frame_bad` are never asserted together; at most one pulse per frame.
- **Back-to-back frames** (header immediately after checksum) sustain 100% throughput with no dead cycle.
- **Outputs:** all registered; `out_valid`=0 holds `out_d` at its last value.

## Configuration

- `TS_FRAME_CSUM_EN` defined: the checksum word must equal `sum`; a mismatch makes the frame bad.
- Not defined:
  - The checksum word is still required (legal `rx_k`=00 with `rx_err`=0) but its value is ignored.
  - The `sum` adder is removed.
  - Frame validity depends only on framing and error flags.

## Test plan

- **Reset:** drive `reset` high mid-frame → all outputs 0 within the cycle; no `frame_bad` pulse follows.
- **Clean stream:** 5 back-to-back frames, `NDATA`=6, header 16'h12BC, data 16'h0001..16'h0006, checksum 16'h12D1 → 30 `out_valid` words with 1-cycle latency, `out_bx`=8'h12, 5 `frame_good` pulses, `aligned` rises with the 4th pulse, `good_count`=5, `bad_count`=0.
- **Decode error:** after lock, assert `rx_err` on data word 3 → `frame_bad` next cycle, `aligned` drops, no `out_eof`, `bad_count`=1. Four further good frames → `aligned` reasserts.
- **Checksum corruption:** send checksum 16'h12D0 → with `TS_FRAME_CSUM_EN`, `frame_bad`; without it, `frame_good`.
- **Early header:** header after data word 4 → `frame_bad` for the old frame, and the new frame completes good with the new `out_bx`.
- **Saturation:** force `good_count` near limit (or run a long stream) → stops at 32'hFFFFFFFF with no wrap.
